ctrl_pipe_chain: RTL and testbench
==================================

Name: ctrl_pipe_chain

Overview:
- Parametrised successor of the per-stage control-signal pipeline registers behind the main/ALU decoders.
- Carries a WIDTH-bit decoded control word from ID through STAGES back-end stages (default E, M, W, plus one spare).
- Each stage has a valid bit, an independent flush, and a derived effective stall. Stalls propagate from older stages to younger ones, and a bubble is inserted behind a stalled stage.
- Owns the multi-cycle (divider) hold counter at a chosen stage and exports per-stage stall state, replacing the ad-hoc stall-snapshot bit.

Parameters:
- WIDTH, 19, control word bits per stage.
- STAGES, 4, number of back-end stages. Index 0 is the youngest (EX); STAGES-1 is the oldest.
- MC_STAGE, 1, stage index where multi-cycle ops are held.
- MC_LAT, 34, total cycles a multi-cycle op occupies MC_STAGE. Must be >= 1.
- CW, $clog2(MC_LAT+1), counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode stage presents a real instruction
- in_ctrl  in  WIDTH  decoded control word from ID
- in_mc  in  1  instruction is multi-cycle (div/divu)
- stall_ext  in  STAGES  external stall request per stage
- flush  in  STAGES  synchronous clear per stage
- flush_upto  in  1  exception flush: clear every stage with index <= flush_idx
- flush_idx  in  $clog2(STAGES)  stage bound for flush_upto
- out_ctrl  out  STAGES*WIDTH  stage i control word at bits [i*WIDTH +: WIDTH]
- out_valid  out  STAGES  per-stage valid
- stall_eff  out  STAGES  effective stall per stage (combinational)
- in_ready  out  1  equals ~stall_eff[0]; ID may advance
- mc_busy  out  1  multi-cycle op holding MC_STAGE
- mc_done  out  1  one-cycle pulse on the last hold cycle

Behaviour:
- Reset (async, rst=1): every out_valid=0, every out_ctrl=0, all mc tags=0, counter=0, mc_busy=0, mc_done=0.
- Stall chain (combinational), computed from the oldest stage down:
  - stall_eff[STAGES-1] = stall_ext[STAGES-1] | (MC_STAGE==STAGES-1 & mc_busy).
  - stall_eff[i] = stall_ext[i] | stall_eff[i+1] | (i==MC_STAGE & mc_busy).
- Per-stage update on the rising clock edge, first matching rule wins:
  1. Clear if flush[i] | (flush_upto & i<=flush_idx): valid=0, ctrl=0, mc=0.
  2. Hold if stall_eff[i]: contents unchanged.
  3. Load otherwise.
     - Stage 0 takes {in_valid, in_ctrl, in_mc}. It loads a bubble if in_valid=0.
     - Stage i>0 takes stage i-1's contents if stall_eff[i-1]=0. If stall_eff[i-1]=1 it loads a bubble (valid=0, ctrl=0, mc=0).
- A bubble's ctrl is all zeros, so downstream write enables are inert.
- Latency: 1 cycle per stage. An unstalled instruction appears in stage i i+1 cycles after being presented.
- Multi-cycle counter:
  - Loads MC_LAT-1 on the edge where a valid mc entry is loaded into MC_STAGE.
  - Decrements by 1 each cycle while nonzero.
  - mc_busy = out_valid[MC_STAGE] & mc[MC_STAGE] & (cnt!=0).
  - mc_done = 1 in the cycle cnt==1 and the stage is not being flushed.
  - The entry occupies MC_STAGE for exactly MC_LAT cycles if nothing older stalls. MC_LAT=1 gives no hold and no mc_done pulse.
  - An external stall on an older stage extends residence but does not pause the counter.
- Boundaries:
  - Flush of MC_STAGE, or flush_upto covering it, forces cnt=0 on the same edge. mc_busy drops the next cycle.
  - Flush and stall on the same stage: flush wins.
  - Flush on stage i while stage i-1 advances into it: flush wins and the incoming entry is lost.
  - A younger stage is held by an older stall even if its own stall_ext=0.
  - flush_idx >= STAGES clears all stages.
  - Reset mid-hold aborts immediately with cnt=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - control-word field offsets (memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[7:0], hilo_write, jal, jr, bal, memen, cp0we);
  - CTRL_W = 19;
  - stage index constants STG_E=0, STG_M=1, STG_W=2.
- One sub-module, ctrl_stage_reg: per-stage register {valid, mc, ctrl} with async reset, clear, and enable, instantiated STAGES times in a generate loop. Stall chain and counter live in the top.

Test Plan:
- Streaming: in_valid=1 with ctrl 0x1, 0x2, 0x3 on consecutive cycles, no stalls -> out_ctrl stage 2 shows 0x1 at cycle 3, with out_valid[2:0]=111 from cycle 3.
- Backward stall: stall_ext[2]=1 for 2 cycles with a full pipe -> stall_eff=0111 and in_ready=0 for those cycles; stage 3 receives two bubbles (valid=0, ctrl=0); stages 0–2 unchanged.
- Multi-cycle: MC_LAT=4, a div enters stage 1 at cycle t -> mc_busy=1 for cycles t..t+2, mc_done=1 at t+2, and the div moves to stage 2 at t+4; stage 2 receives 3 bubbles meanwhile.
- Flush during hold: flush[1]=1 at cycle t+1 of the above -> stage 1 clears, cnt=0, mc_busy=0 at t+2, no mc_done.
- Exception flush: flush_upto=1, flush_idx=1, with stall_ext[0]=1 in the same cycle -> stages 0 and 1 cleared (flush beats stall); stages 2 and 3 advance normally.
- Async reset asserted mid-hold (cnt=20) -> all outputs 0 within the same cycle; in_ready=1 after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control-word field layout and back-end stage indices shared by the decoder
// and the control pipeline.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 19;

  localparam int unsigned CTRL_MEMTOREG    = 0;
  localparam int unsigned CTRL_MEMWRITE    = 1;
  localparam int unsigned CTRL_ALUSRC      = 2;
  localparam int unsigned CTRL_REGDST      = 3;
  localparam int unsigned CTRL_REGWRITE    = 4;
  localparam int unsigned CTRL_ALUCTRL_LSB = 5;
  localparam int unsigned CTRL_ALUCTRL_W   = 8;
  localparam int unsigned CTRL_HILO_WRITE  = 13;
  localparam int unsigned CTRL_JAL         = 14;
  localparam int unsigned CTRL_JR          = 15;
  localparam int unsigned CTRL_BAL         = 16;
  localparam int unsigned CTRL_MEMEN       = 17;
  localparam int unsigned CTRL_CP0WE       = 18;

  localparam int unsigned STG_E = 0;
  localparam int unsigned STG_M = 1;
  localparam int unsigned STG_W = 2;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of control state: {valid, mc tag, control word}.
// Clear beats enable; a clear or reset leaves an inert all-zero bubble.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CTRL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             mc_i,
  input  logic [WIDTH-1:0] ctrl_i,
  output logic             valid_o,
  output logic             mc_o,
  output logic [WIDTH-1:0] ctrl_o
);

  logic             valid_q;
  logic             mc_q;
  logic [WIDTH-1:0] ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mc_q    <= 1'b0;
      ctrl_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      mc_q    <= 1'b0;
      ctrl_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      mc_q    <= mc_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign mc_o    = mc_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Back-end control-word pipeline with per-stage flush, a backward stall chain
// and the multi-cycle hold counter at MC_STAGE.
module ctrl_pipe_chain
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = CTRL_W,
  parameter int unsigned STAGES   = 4,
  parameter int unsigned MC_STAGE = STG_M,
  parameter int unsigned MC_LAT   = 34,
  parameter int unsigned CW       = $clog2(MC_LAT + 1),
  parameter int unsigned IW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_mc,
  input  logic [STAGES-1:0]       stall_ext,
  input  logic [STAGES-1:0]       flush,
  input  logic                    flush_upto,
  input  logic [IW-1:0]           flush_idx,
  output logic [STAGES*WIDTH-1:0] out_ctrl,
  output logic [STAGES-1:0]       out_valid,
  output logic [STAGES-1:0]       stall_eff,
  output logic                    in_ready,
  output logic                    mc_busy,
  output logic                    mc_done
);

  logic [STAGES-1:0] stage_v;
  logic [STAGES-1:0] stage_mc;
  logic [WIDTH-1:0]  stage_ctrl [STAGES];

  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] clr;
  logic [STAGES-1:0] ld_v;
  logic [STAGES-1:0] ld_mc;
  logic [WIDTH-1:0]  ld_ctrl [STAGES];

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mc_load;

  assign mc_busy = stage_v[MC_STAGE] & stage_mc[MC_STAGE] & (cnt_q != '0);

  // Stalls ripple from the oldest stage towards EX.
  always_comb begin : stall_chain
    logic older;
    older = 1'b0;
    stall = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      stall[i] = stall_ext[i] | older | ((i == int'(MC_STAGE)) & mc_busy);
      older    = stall[i];
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      clr[i] = flush[i] | (flush_upto & (i <= int'(flush_idx)));
    end
  end

  // A stage whose predecessor is held receives a bubble instead of a duplicate.
  always_comb begin
    ld_v       = '0;
    ld_mc      = '0;
    ld_ctrl    = '{default: '0};
    ld_v[0]    = in_valid;
    ld_mc[0]   = in_valid & in_mc;
    ld_ctrl[0] = in_valid ? in_ctrl : '0;
    for (int i = 1; i < int'(STAGES); i++) begin
      ld_v[i]    = ~stall[i-1] & stage_v[i-1];
      ld_mc[i]   = ~stall[i-1] & stage_mc[i-1];
      ld_ctrl[i] = stall[i-1] ? '0 : stage_ctrl[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ctrl_stage_reg #(
      .WIDTH (WIDTH)
    ) u_stage_reg (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr[g]),
      .en_i    (~stall[g]),
      .valid_i (ld_v[g]),
      .mc_i    (ld_mc[g]),
      .ctrl_i  (ld_ctrl[g]),
      .valid_o (stage_v[g]),
      .mc_o    (stage_mc[g]),
      .ctrl_o  (stage_ctrl[g])
    );
    assign out_ctrl[g*WIDTH +: WIDTH] = stage_ctrl[g];
  end

  // The counter keeps running under older stalls; only a flush or reset stops it.
  always_comb begin
    mc_load = ~clr[MC_STAGE] & ~stall[MC_STAGE] & ld_v[MC_STAGE] & ld_mc[MC_STAGE];
    cnt_d   = cnt_q;
    if (clr[MC_STAGE]) begin
      cnt_d = '0;
    end else if (mc_load) begin
      cnt_d = CW'(MC_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mc_done   = (cnt_q == CW'(1)) & ~clr[MC_STAGE];
  assign out_valid = stage_v;
  assign stall_eff = stall;
  assign in_ready  = ~stall[0];

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed and randomised stimulus for ctrl_pipe_chain, checked every cycle
// against a stage-array model that tracks multi-cycle residence by age.
module tb_ctrl_pipe_chain;

  localparam int STAGES   = 4;
  localparam int WIDTH    = 19;
  localparam int MC_STAGE = 1;
  localparam int MC_LAT   = 24;
  localparam int IW       = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_mc;
  logic [STAGES-1:0]       stall_ext;
  logic [STAGES-1:0]       flush;
  logic                    flush_upto;
  logic [IW-1:0]           flush_idx;
  logic [STAGES*WIDTH-1:0] out_ctrl;
  logic [STAGES-1:0]       out_valid;
  logic [STAGES-1:0]       stall_eff;
  logic                    in_ready;
  logic                    mc_busy;
  logic                    mc_done;

  ctrl_pipe_chain #(
    .WIDTH    (WIDTH),
    .STAGES   (STAGES),
    .MC_STAGE (MC_STAGE),
    .MC_LAT   (MC_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ctrl    (in_ctrl),
    .in_mc      (in_mc),
    .stall_ext  (stall_ext),
    .flush      (flush),
    .flush_upto (flush_upto),
    .flush_idx  (flush_idx),
    .out_ctrl   (out_ctrl),
    .out_valid  (out_valid),
    .stall_eff  (stall_eff),
    .in_ready   (in_ready),
    .mc_busy    (mc_busy),
    .mc_done    (mc_done)
  );

  always #5 clk = ~clk;

  // Reference state: one entry per stage plus the age of the entry held in MC_STAGE.
  logic                    m_v    [STAGES];
  logic                    m_mc   [STAGES];
  logic [WIDTH-1:0]        m_ctrl [STAGES];
  int                      m_age;
  logic [STAGES-1:0]       e_stall;
  logic [STAGES-1:0]       e_clr;
  logic [STAGES-1:0]       e_v;
  logic [STAGES*WIDTH-1:0] e_pk;
  logic                    e_busy;
  logic                    e_done;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  int done_cnt;
  int arrive_j;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < STAGES; i++) begin
      m_v[i]    = 1'b0;
      m_mc[i]   = 1'b0;
      m_ctrl[i] = '0;
    end
    m_age = 0;
  endtask

  task automatic model_eval();
    bit older = 1'b0;
    e_busy = m_v[MC_STAGE] && m_mc[MC_STAGE] && m_age > 0 && m_age < MC_LAT;
    for (int i = STAGES - 1; i >= 0; i--) begin
      e_stall[i] = stall_ext[i] || older || (i == MC_STAGE && e_busy);
      older      = e_stall[i];
      e_clr[i]   = flush[i] || (flush_upto && i <= int'(flush_idx));
      e_v[i]     = m_v[i];
      e_pk[i*WIDTH +: WIDTH] = m_ctrl[i];
    end
    e_done = e_busy && m_age == MC_LAT - 1 && !e_clr[MC_STAGE];
  endtask

  task automatic model_update();
    logic             nv [STAGES];
    logic             nm [STAGES];
    logic [WIDTH-1:0] nc [STAGES];
    for (int i = 0; i < STAGES; i++) begin
      nv[i] = m_v[i];
      nm[i] = m_mc[i];
      nc[i] = m_ctrl[i];
      if (e_clr[i]) begin
        nv[i] = 1'b0;
        nm[i] = 1'b0;
        nc[i] = '0;
      end else if (e_stall[i]) begin
        // holds
      end else if (i == 0) begin
        nv[i] = in_valid;
        nm[i] = in_valid && in_mc;
        nc[i] = in_valid ? in_ctrl : '0;
      end else if (e_stall[i-1]) begin
        nv[i] = 1'b0;
        nm[i] = 1'b0;
        nc[i] = '0;
      end else begin
        nv[i] = m_v[i-1];
        nm[i] = m_mc[i-1];
        nc[i] = m_ctrl[i-1];
      end
    end
    if (e_clr[MC_STAGE]) m_age = 0;
    else if (!e_stall[MC_STAGE]) m_age = (nv[MC_STAGE] && nm[MC_STAGE]) ? 1 : 0;
    else if (m_age > 0 && m_age < MC_LAT) m_age++;
    for (int i = 0; i < STAGES; i++) begin
      m_v[i]    = nv[i];
      m_mc[i]   = nm[i];
      m_ctrl[i] = nc[i];
    end
  endtask

  task automatic model_cycle();
    model_eval();
    check_eq("out_valid", 128'(out_valid), 128'(e_v));
    check_eq("out_ctrl", 128'(out_ctrl), 128'(e_pk));
    check_eq("stall_eff", 128'(stall_eff), 128'(e_stall));
    check_eq("in_ready", 128'(in_ready), 128'(!e_stall[0]));
    check_eq("mc_busy", 128'(mc_busy), 128'(e_busy));
    check_eq("mc_done", 128'(mc_done), 128'(e_done));
    model_update();
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] c, input logic mc,
                     input logic [STAGES-1:0] se, input logic [STAGES-1:0] fl,
                     input logic fu, input logic [IW-1:0] fi);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_ctrl    = c;
    in_mc      = mc;
    stall_ext  = se;
    flush      = fl;
    flush_upto = fu;
    flush_idx  = fi;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [STAGES-1:0] rand_mask(input int unsigned n);
    logic [STAGES-1:0] m;
    for (int i = 0; i < STAGES; i++) m[i] = ($urandom_range(n - 1) == 0);
    return m;
  endfunction

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_ctrl    = '0;
    in_mc      = 1'b0;
    stall_ext  = '0;
    flush      = '0;
    flush_upto = 1'b0;
    flush_idx  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 128'(out_valid), 128'(0));
    check_eq("rst_ctrl", 128'(out_ctrl), 128'(0));
    check_eq("rst_busy", 128'(mc_busy), 128'(0));
    check_eq("rst_done", 128'(mc_done), 128'(0));
    check_eq("rst_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;

    // Streaming: ctrl 1 reaches stage 2 three cycles after being presented.
    for (int k = 1; k <= 4; k++) cyc(1'b1, WIDTH'(k), 1'b0, '0, '0, 1'b0, '0);
    check_eq("stream_s2_ctrl", 128'(out_ctrl[2*WIDTH +: WIDTH]), 128'(1));
    check_eq("stream_valid", 128'(out_valid[2:0]), 128'(3'b111));
    cyc(1'b1, 19'd5, 1'b0, '0, '0, 1'b0, '0);

    // Backward stall on stage 2 with a full pipe.
    cyc(1'b1, 19'd6, 1'b0, 4'b0100, '0, 1'b0, '0);
    check_eq("bstall_eff", 128'(stall_eff), 128'(4'b0111));
    check_eq("bstall_ready", 128'(in_ready), 128'(0));
    cyc(1'b1, 19'd7, 1'b0, 4'b0100, '0, 1'b0, '0);
    check_eq("bstall_s3_valid", 128'(out_valid[3]), 128'(0));
    check_eq("bstall_s3_ctrl", 128'(out_ctrl[3*WIDTH +: WIDTH]), 128'(0));
    check_eq("bstall_s0_held", 128'(out_ctrl[0 +: WIDTH]), 128'(5));
    check_eq("bstall_s2_held", 128'(out_ctrl[2*WIDTH +: WIDTH]), 128'(3));
    idle(5);

    // Multi-cycle op held in stage 1 for MC_LAT cycles.
    busy_cnt = 0;
    done_cnt = 0;
    arrive_j = 0;
    cyc(1'b1, 19'h55, 1'b1, '0, '0, 1'b0, '0);
    for (int j = 1; j <= 40; j++) begin
      cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      if (mc_busy) busy_cnt++;
      if (mc_done) done_cnt++;
      if (arrive_j == 0 && out_valid[2] && out_ctrl[2*WIDTH +: WIDTH] == 19'h55) arrive_j = j;
    end
    check_eq("mc_busy_cycles", 128'(busy_cnt), 128'(MC_LAT - 1));
    check_eq("mc_done_pulses", 128'(done_cnt), 128'(1));
    check_eq("mc_arrive_s2", 128'(arrive_j), 128'(MC_LAT + 2));

    // Flush stage 1 one cycle into the hold.
    busy_cnt = 0;
    done_cnt = 0;
    cyc(1'b1, 19'h66, 1'b1, '0, '0, 1'b0, '0);
    for (int j = 1; j <= 30; j++) begin
      cyc(1'b0, '0, 1'b0, '0, (j == 3) ? 4'b0010 : 4'b0000, 1'b0, '0);
      if (mc_busy) busy_cnt++;
      if (mc_done) done_cnt++;
      if (j == 4) check_eq("mcflush_s1_valid", 128'(out_valid[1]), 128'(0));
    end
    check_eq("mcflush_busy", 128'(busy_cnt), 128'(2));
    check_eq("mcflush_done", 128'(done_cnt), 128'(0));

    // Exception flush of stages 0..1 while stage 0 also requests a stall.
    for (int k = 1; k <= 4; k++) cyc(1'b1, WIDTH'(16 + k), 1'b0, '0, '0, 1'b0, '0);
    cyc(1'b1, 19'h15, 1'b0, 4'b0001, '0, 1'b1, 2'd1);
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    check_eq("xflush_valid", 128'(out_valid), 128'(4'b1100));
    check_eq("xflush_s3", 128'(out_ctrl[3*WIDTH +: WIDTH]), 128'(18));
    check_eq("xflush_s2", 128'(out_ctrl[2*WIDTH +: WIDTH]), 128'(19));
    idle(4);

    // Asynchronous reset in the middle of a hold.
    cyc(1'b1, 19'h77, 1'b1, '0, '0, 1'b0, '0);
    idle(5);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 128'(out_valid), 128'(0));
    check_eq("arst_ctrl", 128'(out_ctrl), 128'(0));
    check_eq("arst_busy", 128'(mc_busy), 128'(0));
    check_eq("arst_done", 128'(mc_done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("arst_ready", 128'(in_ready), 128'(1));

    // Randomised traffic; flushes only in the first half so long holds can complete.
    for (int k = 0; k < 1600; k++) begin
      bit allow_fl;
      allow_fl = (k < 800);
      cyc($urandom_range(3) != 0, WIDTH'($urandom), $urandom_range(3) == 0,
          rand_mask(10),
          allow_fl ? rand_mask(40) : 4'b0000,
          allow_fl && ($urandom_range(49) == 0),
          IW'($urandom_range(3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
